// File: rtl/trivium_sched.sv
// Two-requester scheduler for a shared Trivium core: round-robin grant, key/IV load,
// warm-up counting, keystream deserialisation and a stall watchdog.
module trivium_sched #(
  parameter int KS_LEN  = 128,
  parameter int WARMUP  = 1152,
  parameter int TIMEOUT = 2047
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic [1:0]        req,
  input  logic [79:0]       key0,
  input  logic [79:0]       iv0,
  input  logic [79:0]       key1,
  input  logic [79:0]       iv1,
  input  logic              ack,
  output logic              ks_vld,
  output logic              ks_id,
  output logic [KS_LEN-1:0] ks,
  output logic              err,
  output logic [79:0]       tv_kin,
  output logic [79:0]       tv_din,
  output logic              tv_krdy,
  output logic              tv_drdy,
  output logic              tv_encdec,
  output logic              tv_en,
  output logic              tv_rstn,
  input  logic              tv_bsy,
  input  logic              tv_kvld,
  input  logic              tv_dvld,
  input  logic              tv_dout
);

  typedef enum logic [2:0] {IDLE, KEY, KWAIT, IV, RUN, OUT, ABORT} state_t;

  localparam logic [11:0] SC_LO  = 12'(WARMUP + 1);
  localparam logic [11:0] SC_HI  = 12'(WARMUP + KS_LEN);
  localparam logic [11:0] WD_MAX = 12'(TIMEOUT);

  state_t            state_q, state_d;
  logic              rr_last_q, rr_last_d;
  logic              gid_q, gid_d;
  logic              key_ok_q, key_ok_d;
  logic [79:0]       last_key_q, last_key_d;
  logic [79:0]       kin_q, kin_d;
  logic [79:0]       din_q, din_d;
  logic [11:0]       sc_q, sc_d;
  logic [11:0]       wd_q, wd_d;
  logic [KS_LEN-1:0] ks_q, ks_d;
  logic              winner;
  logic [79:0]       win_key;
  logic [11:0]       sc_inc;

  // A lone request wins outright; on a tie the requester not served last wins.
  always_comb begin
    winner = 1'b0;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      default: winner = ~rr_last_q;
    endcase
    win_key = winner ? key1 : key0;
    sc_inc  = sc_q + 12'd1;
  end

  always_comb begin
    state_d    = state_q;
    rr_last_d  = rr_last_q;
    gid_d      = gid_q;
    key_ok_d   = key_ok_q;
    last_key_d = last_key_q;
    kin_d      = kin_q;
    din_d      = din_q;
    sc_d       = sc_q;
    ks_d       = ks_q;
    case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          gid_d   = winner;
          kin_d   = win_key;
          din_d   = winner ? iv1 : iv0;
          state_d = (key_ok_q && (win_key == last_key_q)) ? IV : KEY;
        end
      end
      KEY: begin
        last_key_d = kin_q;
        state_d    = KWAIT;
      end
      KWAIT: begin
        if (wd_q == WD_MAX) begin
          state_d = ABORT;
        end else if (tv_kvld) begin
          key_ok_d = 1'b1;
          state_d  = IV;
        end
      end
      IV: begin
        sc_d    = 12'd0;
        state_d = RUN;
      end
      RUN: begin
        // A result flagged before the full warm-up plus capture count is untrustworthy.
        if (wd_q == WD_MAX) begin
          state_d = ABORT;
        end else if (tv_dvld) begin
          state_d = (sc_q >= SC_HI) ? OUT : ABORT;
        end else if (tv_bsy) begin
          sc_d = sc_inc;
          if ((sc_inc >= SC_LO) && (sc_inc <= SC_HI)) begin
            ks_d = {ks_q[KS_LEN-2:0], tv_dout};
          end
        end
      end
      OUT: begin
        rr_last_d = gid_q;
        if (ack) state_d = IDLE;
      end
      ABORT: begin
        key_ok_d = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) begin
      wd_d = 12'd0;
    end else if ((state_q == KWAIT) || (state_q == RUN)) begin
      wd_d = wd_q + 12'd1;
    end else begin
      wd_d = 12'd0;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q    <= IDLE;
      rr_last_q  <= 1'b1;
      gid_q      <= 1'b0;
      key_ok_q   <= 1'b0;
      last_key_q <= '0;
      kin_q      <= '0;
      din_q      <= '0;
      sc_q       <= '0;
      wd_q       <= '0;
      ks_q       <= '0;
    end else begin
      state_q    <= state_d;
      rr_last_q  <= rr_last_d;
      gid_q      <= gid_d;
      key_ok_q   <= key_ok_d;
      last_key_q <= last_key_d;
      kin_q      <= kin_d;
      din_q      <= din_d;
      sc_q       <= sc_d;
      wd_q       <= wd_d;
      ks_q       <= ks_d;
    end
  end

  assign ks_vld    = (state_q == OUT);
  assign ks_id     = gid_q;
  assign ks        = ks_q;
  assign err       = (state_q == ABORT);
  assign tv_kin    = kin_q;
  assign tv_din    = din_q;
  assign tv_krdy   = (state_q == KEY);
  assign tv_drdy   = (state_q == IV);
  assign tv_encdec = 1'b0;
  assign tv_en     = (state_q != ABORT);
  assign tv_rstn   = (state_q != ABORT);

endmodule

// File: tb/tb_trivium_sched.sv
// Bench for trivium_sched: a behavioural Trivium core drives the DUT, and a golden
// keystream model fills a scoreboard that is popped as results appear.
module tb_trivium_sched;
  localparam int KS_LEN     = 128;
  localparam int WARMUP     = 1152;
  localparam int TIMEOUT    = 2047;
  localparam int RUN_BUDGET = 3000;

  logic          CLK = 1'b0;
  logic          RSTn;
  logic [1:0]    req;
  logic [79:0]   key0, iv0, key1, iv1;
  logic          ack;
  logic          ks_vld, ks_id, err;
  logic [127:0]  ks;
  logic [79:0]   tv_kin, tv_din;
  logic          tv_krdy, tv_drdy, tv_encdec, tv_en, tv_rstn;
  logic          tv_bsy, tv_kvld, tv_dvld, tv_dout;

  int checks   = 0;
  int failures = 0;
  int krdyCount = 0;
  int drdyCount = 0;
  bit noKvld = 1'b0;

  typedef struct {
    logic         id;
    logic [127:0] ks;
  } exp_t;
  exp_t sb[$];

  always #5 CLK = ~CLK;

  trivium_sched #(.KS_LEN(KS_LEN), .WARMUP(WARMUP), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RSTn(RSTn), .req(req), .key0(key0), .iv0(iv0), .key1(key1), .iv1(iv1),
    .ack(ack), .ks_vld(ks_vld), .ks_id(ks_id), .ks(ks), .err(err),
    .tv_kin(tv_kin), .tv_din(tv_din), .tv_krdy(tv_krdy), .tv_drdy(tv_drdy),
    .tv_encdec(tv_encdec), .tv_en(tv_en), .tv_rstn(tv_rstn),
    .tv_bsy(tv_bsy), .tv_kvld(tv_kvld), .tv_dvld(tv_dvld), .tv_dout(tv_dout)
  );

  function automatic logic [288:1] trivInit(input logic [79:0] k, input logic [79:0] v);
    logic [288:1] s;
    s = '0;
    for (int j = 0; j < 80; j++) begin
      s[1 + j]  = k[j];
      s[94 + j] = v[j];
    end
    s[286] = 1'b1;
    s[287] = 1'b1;
    s[288] = 1'b1;
    return s;
  endfunction

  function automatic logic trivZ(input logic [288:1] s);
    return s[66] ^ s[93] ^ s[162] ^ s[177] ^ s[243] ^ s[288];
  endfunction

  function automatic logic [288:1] trivStep(input logic [288:1] s);
    logic t1, t2, t3;
    logic [288:1] n;
    t1 = s[66] ^ s[93] ^ (s[91] & s[92]) ^ s[171];
    t2 = s[162] ^ s[177] ^ (s[175] & s[176]) ^ s[264];
    t3 = s[243] ^ s[288] ^ (s[286] & s[287]) ^ s[69];
    n[93:2]    = s[92:1];
    n[1]       = t3;
    n[177:95]  = s[176:94];
    n[94]      = t1;
    n[288:179] = s[287:178];
    n[178]     = t2;
    return n;
  endfunction

  function automatic logic [127:0] ksGold(input logic [79:0] k, input logic [79:0] v);
    logic [288:1] s;
    logic [127:0] r;
    s = trivInit(k, v);
    r = '0;
    for (int i = 0; i < WARMUP + KS_LEN; i++) begin
      if (i >= WARMUP) r = {r[126:0], trivZ(s)};
      s = trivStep(s);
    end
    return r;
  endfunction

  // Behavioural core: key acknowledged two cycles after its strobe, then one output bit
  // per busy cycle for the whole warm-up plus capture window, then a one-cycle done flag.
  logic [288:1] cs;
  logic [79:0]  ckey;
  int           ccnt;
  int           kdel;
  logic         cdv;

  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn || !tv_rstn) begin
      cs   <= '0;
      ckey <= '0;
      ccnt <= 0;
      kdel <= 0;
      cdv  <= 1'b0;
    end else begin
      cdv <= 1'b0;
      if (tv_krdy) begin
        ckey <= tv_kin;
        kdel <= 2;
      end else if (kdel != 0) begin
        kdel <= kdel - 1;
      end
      if (tv_drdy) begin
        cs   <= trivInit(ckey, tv_din);
        ccnt <= WARMUP + KS_LEN;
      end else if (ccnt != 0) begin
        cs   <= trivStep(cs);
        ccnt <= ccnt - 1;
        if (ccnt == 1) cdv <= 1'b1;
      end
    end
  end

  assign tv_bsy  = (ccnt != 0);
  assign tv_dout = trivZ(cs);
  assign tv_dvld = cdv;
  assign tv_kvld = (kdel == 1) && !noKvld;

  always @(posedge CLK) begin
    if (tv_krdy === 1'b1) krdyCount <= krdyCount + 1;
    if (tv_drdy === 1'b1) drdyCount <= drdyCount + 1;
  end

  task automatic applyReset();
    RSTn = 1'b0;
    req  = 2'b00;
    ack  = 1'b0;
    repeat (3) @(negedge CLK);
    RSTn = 1'b1;
    @(negedge CLK);
  endtask

  task automatic waitResult(input int budget, output bit got, output logic gotId,
                            output logic [127:0] gotKs, output int cycles);
    got = 1'b0;
    gotId = 1'b0;
    gotKs = '0;
    cycles = 0;
    while (!got && cycles < budget) begin
      @(negedge CLK);
      cycles++;
      if (ks_vld === 1'b1) begin
        got = 1'b1;
        gotId = ks_id;
        gotKs = ks;
      end
    end
  endtask

  task automatic test_reset();
    RSTn = 1'b0; req = 2'b00; ack = 1'b0;
    key0 = '0; iv0 = '0; key1 = '0; iv1 = '0;
    #1;
    checks++; if (ks_vld !== 1'b0) begin failures++; $display("[TB] FAIL reset_ks_vld got %b want 0", ks_vld); end
    checks++; if (ks_id !== 1'b0) begin failures++; $display("[TB] FAIL reset_ks_id got %b want 0", ks_id); end
    checks++; if (ks !== 128'd0) begin failures++; $display("[TB] FAIL reset_ks got %h want 0", ks); end
    checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL reset_err got %b want 0", err); end
    checks++; if ({tv_krdy, tv_drdy, tv_encdec} !== 3'b000) begin failures++; $display("[TB] FAIL reset_strobes got %b want 000", {tv_krdy, tv_drdy, tv_encdec}); end
    checks++; if ({tv_en, tv_rstn} !== 2'b11) begin failures++; $display("[TB] FAIL reset_en_rstn got %b want 11", {tv_en, tv_rstn}); end
    checks++; if ({tv_kin, tv_din} !== 160'd0) begin failures++; $display("[TB] FAIL reset_kin_din got %h want 0", {tv_kin, tv_din}); end
    repeat (3) @(negedge CLK);
    RSTn = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_single();
    bit got; logic gid; logic [127:0] gks; int cyc; int k0, d0; exp_t e;
    key0 = '0; iv0 = '0;
    sb.push_back('{1'b0, ksGold(80'd0, 80'd0)});
    k0 = krdyCount; d0 = drdyCount;
    req = 2'b01;
    repeat (10) @(negedge CLK);
    req = 2'b00;
    waitResult(RUN_BUDGET, got, gid, gks, cyc);
    e = (sb.size() != 0) ? sb.pop_front() : '{1'bx, 'x};
    checks++; if (!got) begin failures++; $display("[TB] FAIL single_timeout got none want ks_vld within %0d", RUN_BUDGET); end
    checks++; if (gid !== e.id) begin failures++; $display("[TB] FAIL single_id got %b want %b", gid, e.id); end
    checks++; if (gks !== e.ks) begin failures++; $display("[TB] FAIL single_ks got %h want %h", gks, e.ks); end
    checks++; if (krdyCount - k0 != 1) begin failures++; $display("[TB] FAIL single_krdy got %0d want 1", krdyCount - k0); end
    checks++; if (drdyCount - d0 != 1) begin failures++; $display("[TB] FAIL single_drdy got %0d want 1", drdyCount - d0); end
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      checks++; if (ks_vld !== 1'b1) begin failures++; $display("[TB] FAIL single_hold got %b want 1", ks_vld); end
    end
    ack = 1'b1;
    @(negedge CLK);
    ack = 1'b0;
    checks++; if (ks_vld !== 1'b0) begin failures++; $display("[TB] FAIL single_ack_clear got %b want 0", ks_vld); end
  endtask

  task automatic test_round_robin();
    bit got; logic gid; logic [127:0] gks; int cyc; int k0; exp_t e;
    applyReset();
    key0 = 80'h0123_4567_89AB_CDEF_0F1E; iv0 = 80'h1111_2222_3333_4444_5555;
    key1 = 80'hFEDC_BA98_7654_3210_A5A5; iv1 = 80'h9999_8888_7777_6666_0001;
    for (int j = 0; j < 4; j++) begin
      if (j % 2 == 0) sb.push_back('{1'b0, ksGold(key0, iv0)});
      else            sb.push_back('{1'b1, ksGold(key1, iv1)});
    end
    k0 = krdyCount;
    req = 2'b11;
    for (int j = 0; j < 4; j++) begin
      waitResult(RUN_BUDGET, got, gid, gks, cyc);
      e = (sb.size() != 0) ? sb.pop_front() : '{1'bx, 'x};
      checks++; if (!got) begin failures++; $display("[TB] FAIL rr_timeout job %0d got none want ks_vld", j); end
      checks++; if (gid !== e.id) begin failures++; $display("[TB] FAIL rr_id job %0d got %b want %b", j, gid, e.id); end
      checks++; if (gks !== e.ks) begin failures++; $display("[TB] FAIL rr_ks job %0d got %h want %h", j, gks, e.ks); end
      if (j == 3) req = 2'b00;
      ack = 1'b1;
      @(negedge CLK);
      ack = 1'b0;
    end
    checks++; if (krdyCount - k0 != 4) begin failures++; $display("[TB] FAIL rr_krdy got %0d want 4", krdyCount - k0); end
  endtask

  task automatic test_key_skip();
    bit got; logic gid; logic [127:0] gks; int lat1, lat2; int k0; exp_t e;
    key1 = 80'h5A5A_3C3C_0F0F_1234_ABCD; iv1 = 80'd1;
    sb.push_back('{1'b1, ksGold(key1, iv1)});
    k0 = krdyCount;
    req = 2'b10;
    waitResult(RUN_BUDGET, got, gid, gks, lat1);
    e = (sb.size() != 0) ? sb.pop_front() : '{1'bx, 'x};
    checks++; if (!got) begin failures++; $display("[TB] FAIL skip1_timeout got none want ks_vld"); end
    checks++; if (gid !== e.id) begin failures++; $display("[TB] FAIL skip1_id got %b want %b", gid, e.id); end
    checks++; if (gks !== e.ks) begin failures++; $display("[TB] FAIL skip1_ks got %h want %h", gks, e.ks); end
    checks++; if (krdyCount - k0 != 1) begin failures++; $display("[TB] FAIL skip1_krdy got %0d want 1", krdyCount - k0); end
    req = 2'b00; ack = 1'b1;
    @(negedge CLK);
    ack = 1'b0;
    iv1 = 80'd2;
    sb.push_back('{1'b1, ksGold(key1, iv1)});
    k0 = krdyCount;
    req = 2'b10;
    waitResult(RUN_BUDGET, got, gid, gks, lat2);
    e = (sb.size() != 0) ? sb.pop_front() : '{1'bx, 'x};
    checks++; if (!got) begin failures++; $display("[TB] FAIL skip2_timeout got none want ks_vld"); end
    checks++; if (gks !== e.ks) begin failures++; $display("[TB] FAIL skip2_ks got %h want %h", gks, e.ks); end
    checks++; if (krdyCount - k0 != 0) begin failures++; $display("[TB] FAIL skip2_krdy got %0d want 0", krdyCount - k0); end
    checks++; if (lat1 - lat2 != 3) begin failures++; $display("[TB] FAIL skip_latency got %0d want 3", lat1 - lat2); end
    req = 2'b00; ack = 1'b1;
    @(negedge CLK);
    ack = 1'b0;
  endtask

  task automatic test_watchdog();
    bit got, seen, stray; logic gid; logic [127:0] gks; int cyc; int k0; exp_t e;
    noKvld = 1'b1;
    key0 = 80'hC0FF_EE00_1234_5678_9ABC; iv0 = 80'h0000_0000_0000_0000_BEEF;
    req = 2'b01;
    seen = 1'b0;
    for (int i = 0; i < TIMEOUT + 200 && !seen; i++) begin
      @(negedge CLK);
      if (err === 1'b1) seen = 1'b1;
    end
    checks++; if (!seen) begin failures++; $display("[TB] FAIL wd_err got none want pulse within %0d", TIMEOUT + 200); end
    checks++; if ({tv_rstn, tv_en} !== 2'b00) begin failures++; $display("[TB] FAIL wd_core_reset got %b want 00", {tv_rstn, tv_en}); end
    req = 2'b00;
    @(negedge CLK);
    checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL wd_err_width got %b want 0", err); end
    checks++; if (tv_rstn !== 1'b1) begin failures++; $display("[TB] FAIL wd_rstn_width got %b want 1", tv_rstn); end
    stray = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ks_vld !== 1'b0) stray = 1'b1;
      @(negedge CLK);
    end
    checks++; if (stray) begin failures++; $display("[TB] FAIL wd_no_result got ks_vld=1 want 0"); end
    noKvld = 1'b0;
    sb.push_back('{1'b0, ksGold(key0, iv0)});
    k0 = krdyCount;
    req = 2'b01;
    waitResult(RUN_BUDGET, got, gid, gks, cyc);
    e = (sb.size() != 0) ? sb.pop_front() : '{1'bx, 'x};
    checks++; if (!got) begin failures++; $display("[TB] FAIL wd_retry_timeout got none want ks_vld"); end
    checks++; if (gks !== e.ks) begin failures++; $display("[TB] FAIL wd_retry_ks got %h want %h", gks, e.ks); end
    checks++; if (krdyCount - k0 != 1) begin failures++; $display("[TB] FAIL wd_retry_krdy got %0d want 1", krdyCount - k0); end
    req = 2'b00; ack = 1'b1;
    @(negedge CLK);
    ack = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    bit got, started; logic gid; logic [127:0] gks; int cyc; int k0, d0; exp_t e;
    iv0 = 80'h0000_1234_0000_5678_0009;
    d0 = drdyCount;
    req = 2'b01;
    started = 1'b0;
    for (int i = 0; i < 50 && !started; i++) begin
      @(negedge CLK);
      if (drdyCount != d0) started = 1'b1;
    end
    checks++; if (!started) begin failures++; $display("[TB] FAIL mid_run_start got no tv_drdy want one within 50"); end
    repeat (600) @(negedge CLK);
    #2 RSTn = 1'b0;
    req = 2'b00;
    #1;
    checks++; if (ks !== 128'd0) begin failures++; $display("[TB] FAIL mid_reset_ks got %h want 0", ks); end
    checks++; if ({tv_kin, tv_din} !== 160'd0) begin failures++; $display("[TB] FAIL mid_reset_kin_din got %h want 0", {tv_kin, tv_din}); end
    checks++; if ({ks_vld, err, tv_krdy, tv_drdy, tv_en, tv_rstn} !== 6'b000011) begin
      failures++; $display("[TB] FAIL mid_reset_ctrl got %b want 000011", {ks_vld, err, tv_krdy, tv_drdy, tv_en, tv_rstn});
    end
    @(negedge CLK);
    RSTn = 1'b1;
    @(negedge CLK);
    sb.push_back('{1'b0, ksGold(key0, iv0)});
    k0 = krdyCount;
    req = 2'b01;
    waitResult(RUN_BUDGET, got, gid, gks, cyc);
    e = (sb.size() != 0) ? sb.pop_front() : '{1'bx, 'x};
    checks++; if (!got) begin failures++; $display("[TB] FAIL mid_retry_timeout got none want ks_vld"); end
    checks++; if (gks !== e.ks) begin failures++; $display("[TB] FAIL mid_retry_ks got %h want %h", gks, e.ks); end
    checks++; if (krdyCount - k0 != 1) begin failures++; $display("[TB] FAIL mid_retry_krdy got %0d want 1", krdyCount - k0); end
    req = 2'b00; ack = 1'b1;
    @(negedge CLK);
    ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit got, stray; logic gid; logic [127:0] gks; int cyc; exp_t e;
    key0 = 80'h7777_0000_1111_2222_3333; iv0 = 80'h0000_0000_0000_0000_00AA;
    sb.push_back('{1'b0, ksGold(key0, iv0)});
    sb.push_back('{1'b0, ksGold(key0, iv0)});
    ack = 1'b1;
    req = 2'b01;
    for (int j = 0; j < 2; j++) begin
      waitResult(RUN_BUDGET, got, gid, gks, cyc);
      e = (sb.size() != 0) ? sb.pop_front() : '{1'bx, 'x};
      checks++; if (!got) begin failures++; $display("[TB] FAIL b2b_timeout job %0d got none want ks_vld", j); end
      checks++; if (gid !== e.id) begin failures++; $display("[TB] FAIL b2b_id job %0d got %b want %b", j, gid, e.id); end
      checks++; if (gks !== e.ks) begin failures++; $display("[TB] FAIL b2b_ks job %0d got %h want %h", j, gks, e.ks); end
      if (j == 1) req = 2'b00;
      @(negedge CLK);
      checks++; if (ks_vld !== 1'b0) begin failures++; $display("[TB] FAIL b2b_pulse job %0d got %b want 0", j, ks_vld); end
    end
    stray = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (ks_vld !== 1'b0) stray = 1'b1;
    end
    ack = 1'b0;
    checks++; if (stray) begin failures++; $display("[TB] FAIL b2b_extra got ks_vld=1 want 0"); end
    checks++; if (sb.size() != 0) begin failures++; $display("[TB] FAIL scoreboard_left got %0d want 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_key_skip();
    test_watchdog();
    test_reset_mid_run();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
